// File: rtl/stim_pkg.sv
// Shared types and constants for the FIFO stimulus driver.
package stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MIXED,
    DRAIN,
    DONE
  } stim_state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the feedback mask in when the bit shifted out was 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 16-bit Galois LFSR that supplies the push/pop coin flips for the MIXED phase.
// Only the two low bits are consumed downstream, so only those are exported.
module stim_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [1:0] bits_o
);
  import stim_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Advance one step when enabled, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // Seed on reset so every run after reset replays the same sequence.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bits_o = lfsr_q[1:0];

endmodule

// File: rtl/fifo_stim_driver.sv
// Constrained push/pop stimulus generator for a FIFO under test. Never pushes into a full
// FIFO or pops an empty one, tags one push as the magic packet, and cross-checks the FIFO
// flags against its own occupancy count.
module fifo_stim_driver #(
  parameter int          DEPTH     = 8,
  parameter int          WIDTH     = 8,
  parameter int          CNTWID    = $clog2(DEPTH) + 1,
  parameter int          NUM_PUSH  = 12,
  parameter int          MAGIC_IDX = 3,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          XOR_MASK  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             full,
  input  logic             empty,
  output logic             push,
  output logic             pop,
  output logic             start,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);
  import stim_pkg::*;

  localparam logic [CNTWID-1:0] DEPTH_C   = CNTWID'(DEPTH);
  localparam logic [15:0]       NUM_C     = 16'(NUM_PUSH);
  localparam logic [31:0]       MAGIC_C   = 32'(MAGIC_IDX);
  localparam logic [WIDTH-1:0]  MASK_C    = WIDTH'(XOR_MASK);

  stim_state_t       state_q, state_d;
  logic [CNTWID-1:0] cnt_q, cnt_d;
  logic [15:0]       push_idx_q, push_idx_d;
  logic [15:0]       pop_total_q, pop_total_d;
  logic              mismatch_q, mismatch_d;
  logic [1:0]        rnd;
  logic              room;

  stim_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (busy),
    .bits_o(rnd)
  );

  assign busy     = (state_q == FILL) || (state_q == MIXED) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign mismatch = mismatch_q;
  assign start    = push && ({16'h0000, push_idx_q} == MAGIC_C);
  assign data_in  = rst ? '0 : (WIDTH'(push_idx_q) ^ MASK_C);

  // Push/pop requests per phase, gated so the FIFO is never over- or under-run.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    push = 1'b0;
    pop  = 1'b0;
    room = !full && (push_idx_q < NUM_C);
    case (state_q)
      FILL:  push = room;
      MIXED: begin
        push = rnd[0] && room;
        pop  = rnd[1] && !empty;
      end
      DRAIN: pop = !empty;
      default: ;
    endcase
    if (rst) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  // Occupancy tracking, flag cross-check and phase sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push_idx_d  = push_idx_q;
    pop_total_d = pop_total_q;
    mismatch_d  = mismatch_q;
    if (busy) begin
      if ((empty != (cnt_q == '0)) || (full != (cnt_q == DEPTH_C))) mismatch_d = 1'b1;
      push_idx_d  = push_idx_q + 16'(push);
      pop_total_d = pop_total_q + 16'(pop);
      // Simultaneous push and pop leaves the count alone; a one-sided move that would
      // leave [0, DEPTH] saturates and is itself treated as a flag disagreement.
      if (push && !pop) begin
        if (cnt_q == DEPTH_C) mismatch_d = 1'b1;
        else                  cnt_d      = cnt_q + 1'b1;
      end else if (pop && !push) begin
        if (cnt_q == '0) mismatch_d = 1'b1;
        else             cnt_d      = cnt_q - 1'b1;
      end
      // Phase exits look at the post-update values so the move happens on the same edge
      // that completes the condition.
      case (state_q)
        FILL:  if ((push_idx_d == NUM_C) || (cnt_d == DEPTH_C)) state_d = MIXED;
        MIXED: if (push_idx_d == NUM_C) state_d = DRAIN;
        DRAIN: if (cnt_d == '0) state_d = DONE;
        default: ;
      endcase
    end else if (go) begin
      state_d     = FILL;
      cnt_d       = '0;
      push_idx_d  = '0;
      pop_total_d = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register sees only pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      push_idx_q  <= '0;
      pop_total_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      push_idx_q  <= push_idx_d;
      pop_total_q <= pop_total_d;
      mismatch_q  <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: directed FILL vectors, then full runs against an ideal FIFO
// and a cycle-level reference model of the driver's rules.
module tb_fifo_stim_driver;

  localparam int          DEPTH     = 8;
  localparam int          NUM_PUSH  = 12;
  localparam int          MAGIC_IDX = 3;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          BUDGET    = 300;

  localparam int M_IDLE = 0, M_FILL = 1, M_MIXED = 2, M_DRAIN = 3, M_DONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, go, full, empty;
  logic       push, pop, start, busy, done, mismatch;
  logic [7:0] data_in;
  logic       push_b, pop_b, start_b, busy_b, done_b, mismatch_b;
  logic [7:0] data_in_b;

  fifo_stim_driver dut (
    .clk(clk), .rst(rst), .go(go), .full(full), .empty(empty),
    .push(push), .pop(pop), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  fifo_stim_driver #(.MAGIC_IDX(20)) dut_b (
    .clk(clk), .rst(rst), .go(go), .full(full), .empty(empty),
    .push(push_b), .pop(pop_b), .start(start_b), .data_in(data_in_b),
    .busy(busy_b), .done(done_b), .mismatch(mismatch_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state and ideal FIFO.
  int          m_st, m_pidx, m_cnt;
  logic [15:0] m_lfsr;
  logic        m_mis;
  logic [7:0]  fifo_q[$];

  // Run bookkeeping.
  int         n_push, n_pop, n_start, n_start_b, pops_full;
  logic       s_push, s_pop, s_start, s_busy, s_done, s_mis, s_done_b;
  logic [7:0] s_data;
  bit         rec_on = 0;
  bit [1:0]   tr_cur[$];
  bit [1:0]   tr_ref[$];

  function automatic logic [15:0] galois_step(input logic [15:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_pidx = 0; m_cnt = 0; m_lfsr = SEED; m_mis = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1; go = 1'b0; full = 1'b0; empty = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    fifo_q.delete();
  endtask

  // One clock: drive at negedge, compare both DUTs with the model, then advance the model.
  task automatic cycle(input logic r, input logic g, input logic fe);
    logic       e_push, e_pop, e_start, e_busy, e_done, room;
    logic [7:0] e_data;
    int         new_cnt;
    @(negedge clk);
    rst = r; go = g;
    full  = (fifo_q.size() == DEPTH);
    empty = (fifo_q.size() == 0) || fe;
    #1;
    e_busy = (m_st == M_FILL) || (m_st == M_MIXED) || (m_st == M_DRAIN);
    e_done = (m_st == M_DONE);
    room   = !full && (m_pidx < NUM_PUSH);
    e_push = 1'b0;
    e_pop  = 1'b0;
    if (!r) begin
      if (m_st == M_FILL) e_push = room;
      if (m_st == M_MIXED) begin
        e_push = m_lfsr[0] && room;
        e_pop  = m_lfsr[1] && !empty;
      end
      if (m_st == M_DRAIN) e_pop = !empty;
    end
    e_start = e_push && (m_pidx == MAGIC_IDX);
    e_data  = r ? 8'h00 : 8'(m_pidx);

    check("push", push, e_push);
    check("pop", pop, e_pop);
    check("start", start, e_start);
    check("data_in", data_in, e_data);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("mismatch", mismatch, m_mis);
    check("push_while_full", push && full, 0);
    check("pop_while_empty", pop && empty, 0);
    check("b_push", push_b, e_push);
    check("b_pop", pop_b, e_pop);
    check("b_start", start_b, 0);
    check("b_busy", busy_b, e_busy);
    check("b_mismatch", mismatch_b, m_mis);

    s_push = push; s_pop = pop; s_start = start; s_data = data_in;
    s_busy = busy; s_done = done; s_mis = mismatch; s_done_b = done_b;
    if (push) n_push++;
    if (pop) n_pop++;
    if (start) n_start++;
    if (start_b) n_start_b++;
    if (pop && full) pops_full++;
    if (rec_on) tr_cur.push_back({push, pop});

    if (r) fifo_q.delete();
    else begin
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (push) fifo_q.push_back(data_in);
    end

    if (r) model_reset();
    else if (!e_busy) begin
      if (g) begin
        m_st = M_FILL; m_pidx = 0; m_cnt = 0;
      end
    end else begin
      if ((empty != (m_cnt == 0)) || (full != (m_cnt == DEPTH))) m_mis = 1'b1;
      new_cnt = m_cnt + int'(e_push) - int'(e_pop);
      if (new_cnt < 0 || new_cnt > DEPTH) m_mis = 1'b1;
      else m_cnt = new_cnt;
      m_pidx += int'(e_push);
      m_lfsr = galois_step(m_lfsr);
      if (m_st == M_FILL && (m_pidx == NUM_PUSH || m_cnt == DEPTH)) m_st = M_MIXED;
      else if (m_st == M_MIXED && m_pidx == NUM_PUSH) m_st = M_DRAIN;
      else if (m_st == M_DRAIN && m_cnt == 0) m_st = M_DONE;
    end
    @(posedge clk);
  endtask

  task automatic start_run(input int gap);
    n_push = 0; n_pop = 0; n_start = 0; n_start_b = 0; pops_full = 0;
    repeat (gap) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  // Run to DONE with optional go pulses while busy and one optional forced-empty glitch.
  task automatic run_to_done(input bit noise, input bit inject);
    int k;
    bit forced, fe;
    k = 0;
    forced = 0;
    while (m_st != M_DONE && k < BUDGET) begin
      fe = inject && !forced && (m_st != M_IDLE) && (fifo_q.size() == 2);
      if (fe) forced = 1;
      cycle(1'b0, noise && ($urandom_range(3) == 0), fe);
      k++;
    end
    check("run_timeout", k < BUDGET, 1);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_checks(input logic exp_mis);
    check("run_pushes", n_push, NUM_PUSH);
    check("run_pops", n_pop, NUM_PUSH);
    check("run_starts", n_start, 1);
    check("run_starts_magic20", n_start_b, 0);
    check("fifo_level_end", fifo_q.size(), 0);
    check("done_end", s_done, 1);
    check("done_end_magic20", s_done_b, 1);
    check("mismatch_end", s_mis, exp_mis);
  endtask

  typedef struct {
    logic r, g, f, e, ep, epo, es;
    logic [7:0] ed;
    logic eb, edn;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    // Directed FILL vectors: reset beats go, then eight back-to-back pushes 0..7.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      vecs[k+2] = '{1'b0, 1'b0, 1'b0, (k == 0), 1'b1, 1'b0, (k == 3), 8'(k), 1'b1, 1'b0};

    hard_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = vecs[i].r; go = vecs[i].g; full = vecs[i].f; empty = vecs[i].e;
      #1;
      check($sformatf("vec%0d_push", i), push, vecs[i].ep);
      check($sformatf("vec%0d_pop", i), pop, vecs[i].epo);
      check($sformatf("vec%0d_start", i), start, vecs[i].es);
      check($sformatf("vec%0d_data", i), data_in, vecs[i].ed);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
      check($sformatf("vec%0d_done", i), done, vecs[i].edn);
      @(posedge clk);
    end

    // Reference run from reset with stray go pulses while busy; its trace is kept.
    hard_reset();
    start_run(0);
    tr_cur.delete();
    rec_on = 1;
    run_to_done(1, 0);
    rec_on = 0;
    tr_ref = tr_cur;
    end_checks(1'b0);
    check("mixed_pop_while_full", pops_full > 0, 1);

    // Back-to-back runs from DONE with random idle gaps; the LFSR carries on.
    for (int r = 0; r < 3; r++) begin
      start_run(int'($urandom_range(0, 5)));
      run_to_done(1, 0);
      end_checks(1'b0);
    end

    // Flag disagreement: empty forced high at occupancy 2; sticky until reset.
    cycle(1'b1, 1'b0, 1'b0);
    start_run(1);
    run_to_done(0, 1);
    end_checks(1'b1);
    start_run(0);
    check("mismatch_kept_after_go", s_mis, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("mismatch_cleared_by_rst", s_mis, 0);

    // Reset mid-MIXED, then the rerun must replay the reference trace exactly.
    start_run(2);
    for (int k = 0; k < 50 && m_st != M_MIXED; k++) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("midrst_push", s_push, 0);
    check("midrst_pop", s_pop, 0);
    check("midrst_start", s_start, 0);
    check("midrst_data", s_data, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("midrst_idle", s_busy, 0);
    start_run(3);
    tr_cur.delete();
    rec_on = 1;
    run_to_done(0, 0);
    rec_on = 0;
    end_checks(1'b0);
    check("replay_length", tr_cur.size(), tr_ref.size());
    for (int i = 0; i < tr_cur.size() && i < tr_ref.size(); i++)
      check($sformatf("replay_cycle%0d", i), tr_cur[i], tr_ref[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
